// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: shared FSM encoding, operation codes and requester IDs for the SR bank arbiter
package sr_bank_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, ACK = 2'd2} state_t;
  localparam logic OP_SET = 1'b1;
  localparam logic OP_RESET = 1'b0;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/sr_cell.sv
// sr_cell: clocked SR storage bit; S and R together hold the cell
module sr_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else if (s && !r) q <= 1'b1;
    else if (r && !s) q <= 1'b0;
  end
endmodule

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin arbiter driving one-cycle set/reset strobes into a bank of SR cells
module sr_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int N_CELLS = 4,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic               op_a,
  input  logic [IDX_W-1:0]   idx_a,
  output logic               ack_a,
  input  logic               req_b,
  input  logic               op_b,
  input  logic [IDX_W-1:0]   idx_b,
  output logic               ack_b,
  output logic [N_CELLS-1:0] Q,
  output logic [N_CELLS-1:0] Qb,
  output logic               busy
);
  state_t state, state_nxt;
  logic lat_op, winner, ptr, grant_b, pulse;
  logic [IDX_W-1:0] lat_idx;
  logic [N_CELLS-1:0] s, r;
  // B wins when it is alone or when both ask and the pointer favours B
  assign grant_b = req_b && (!req_a || ptr == REQ_B);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= REQ_A;
      winner <= REQ_A;
      lat_op <= OP_RESET;
      lat_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req_a || req_b)) begin
        winner <= grant_b;
        lat_op <= grant_b ? op_b : op_a;
        lat_idx <= grant_b ? idx_b : idx_a;
      end
      if (state == ACK) ptr <= ~winner;
    end
  end
  always_comb begin
    state_nxt = IDLE;
    busy = 1'b0;
    ack_a = 1'b0;
    ack_b = 1'b0;
    pulse = 1'b0;
    state_nxt = (state == IDLE) ? ((req_a || req_b) ? PULSE : IDLE) :
                (state == PULSE) ? ACK : IDLE;
    busy = state != IDLE;
    ack_a = state == ACK && winner == REQ_A;
    ack_b = state == ACK && winner == REQ_B;
    pulse = state == PULSE && !rst;
  end
  // out-of-range indices match no cell, so nothing changes but the ack still follows
  always_comb begin
    s = '0;
    r = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      s[i] = pulse && lat_op == OP_SET && lat_idx == IDX_W'(i);
      r[i] = pulse && lat_op == OP_RESET && lat_idx == IDX_W'(i);
    end
  end
  for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
    sr_cell u_cell (.clk(clk), .rst(rst), .s(s[g]), .r(r[g]), .q(Q[g]));
  end
  assign Qb = ~Q;
endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter: table-driven cycle vectors plus a held-request fairness sequence
module tb_sr_bank_arbiter;
  logic clk = 1'b0;
  logic rst, req_a, op_a, req_b, op_b;
  logic [1:0] idx_a, idx_b;
  logic ack_a, ack_b, busy;
  logic [3:0] Q, Qb;
  int tests = 0;
  int fails = 0;
  logic mon_on = 1'b0;

  typedef struct {
    logic rst, ra, oa;
    logic [1:0] ia;
    logic rb, ob;
    logic [1:0] ib;
    logic aa, ab, bz;
    logic [3:0] q;
  } vec_t;
  vec_t tbl[$];

  sr_bank_arbiter #(.N_CELLS(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .idx_a(idx_a), .ack_a(ack_a),
    .req_b(req_b), .op_b(op_b), .idx_b(idx_b), .ack_b(ack_b),
    .Q(Q), .Qb(Qb), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_on) begin
      tests++;
      if (Qb !== ~Q) begin
        fails++;
        $display("FAIL qb_complement: Qb=%b Q=%b", Qb, Q);
      end
    end
  end

  task automatic add(input int rs, ra, oa, ia, rb, ob, ib, aa, ab, bz, q);
    vec_t v;
    v.rst = 1'(rs); v.ra = 1'(ra); v.oa = 1'(oa); v.ia = 2'(ia);
    v.rb = 1'(rb); v.ob = 1'(ob); v.ib = 2'(ib);
    v.aa = 1'(aa); v.ab = 1'(ab); v.bz = 1'(bz); v.q = 4'(q);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
    end
  endtask

  initial begin
    int ack_cyc[4];
    logic who[4];
    int n_ack, cyc;
    rst = 1; req_a = 0; op_a = 0; idx_a = 0; req_b = 0; op_b = 0; idx_b = 0;
    //  rst ra oa ia rb ob ib | aa ab busy Q
    add(1, 0,0,0, 0,0,0, 0,0,0, 4'h0);
    add(0, 1,1,2, 0,0,0, 0,0,1, 4'h0);
    add(0, 1,1,2, 0,0,0, 1,0,1, 4'h4);
    add(0, 0,0,0, 0,0,0, 0,0,0, 4'h4);
    add(1, 0,0,0, 0,0,0, 0,0,0, 4'h0);
    add(0, 1,1,0, 1,1,3, 0,0,1, 4'h0);
    add(0, 1,1,0, 1,1,3, 1,0,1, 4'h1);
    add(0, 0,0,0, 1,1,3, 0,0,0, 4'h1);
    add(0, 0,0,0, 1,1,3, 0,0,1, 4'h1);
    add(0, 0,0,0, 1,1,3, 0,1,1, 4'h9);
    add(0, 0,0,0, 0,0,0, 0,0,0, 4'h9);
    add(0, 1,1,0, 0,0,0, 0,0,1, 4'h9);
    add(0, 1,1,0, 0,0,0, 1,0,1, 4'h9);
    add(0, 0,0,0, 0,0,0, 0,0,0, 4'h9);
    add(1, 0,0,0, 0,0,0, 0,0,0, 4'h0);
    add(0, 1,1,1, 1,0,1, 0,0,1, 4'h0);
    add(0, 1,1,1, 1,0,1, 1,0,1, 4'h2);
    add(0, 0,0,0, 1,0,1, 0,0,0, 4'h2);
    add(0, 0,0,0, 1,0,1, 0,0,1, 4'h2);
    add(0, 0,0,0, 1,0,1, 0,1,1, 4'h0);
    add(0, 0,0,0, 0,0,0, 0,0,0, 4'h0);
    add(0, 1,1,3, 0,0,0, 0,0,1, 4'h0);
    add(0, 1,0,1, 0,0,0, 1,0,1, 4'h8);
    add(0, 0,0,0, 0,0,0, 0,0,0, 4'h8);
    add(0, 1,1,3, 0,0,0, 0,0,1, 4'h8);
    add(1, 1,1,3, 0,0,0, 0,0,0, 4'h0);
    add(0, 1,1,2, 1,1,1, 0,0,1, 4'h0);
    add(0, 1,1,2, 1,1,1, 1,0,1, 4'h4);
    add(0, 0,0,0, 1,1,1, 0,0,0, 4'h4);
    add(0, 0,0,0, 1,1,1, 0,0,1, 4'h4);
    add(0, 0,0,0, 1,1,1, 0,1,1, 4'h6);
    add(0, 0,0,0, 0,0,0, 0,0,0, 4'h6);
    mon_on = 1'b1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req_a = tbl[i].ra; op_a = tbl[i].oa; idx_a = tbl[i].ia;
      req_b = tbl[i].rb; op_b = tbl[i].ob; idx_b = tbl[i].ib;
      @(posedge clk); #1;
      chk("ack_a", i, {3'b0, ack_a}, {3'b0, tbl[i].aa});
      chk("ack_b", i, {3'b0, ack_b}, {3'b0, tbl[i].ab});
      chk("busy", i, {3'b0, busy}, {3'b0, tbl[i].bz});
      chk("q", i, Q, tbl[i].q);
    end
    // both requesters held: grants must alternate A,B,A,B with acks 3 cycles apart
    rst = 1; req_a = 0; req_b = 0;
    @(posedge clk); #1;
    rst = 0; req_a = 1; op_a = 1; idx_a = 0; req_b = 1; op_b = 1; idx_b = 1;
    n_ack = 0;
    cyc = 0;
    while (n_ack < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack_a || ack_b) begin
        ack_cyc[n_ack] = cyc;
        who[n_ack] = ack_b;
        n_ack++;
      end
    end
    req_a = 0; req_b = 0;
    tests++;
    if (n_ack != 4) begin
      fails++;
      $display("FAIL held_timeout: got %0d acks expected 4", n_ack);
    end else begin
      for (int k = 0; k < 4; k++) chk("held_order", k, {3'b0, who[k]}, {3'b0, 1'(k % 2)});
      for (int k = 1; k < 4; k++) chk("held_spacing", k, 4'(ack_cyc[k] - ack_cyc[k-1]), 4'd3);
      chk("held_q", 0, Q, 4'h3);
    end
    @(posedge clk); #1;
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
